cam_match_iter: RTL and testbench

- Upstream stage of the CAM read-out multiplexer.
- Accepts one CAM match vector (one bit per entry) and walks the set bits lowest-index-first.
- Emits one entry index per handshake beat; the index drives the multiplexer's select input, so each matching entry's data is read out in turn.
- Reports a single-cycle miss pulse when a lookup matched nothing.

---
 rtl/cam_match_iter.sv | 132 +++++++++++++
 tb/tb_cam_match_iter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_match_iter.sv
// cam_match_iter
//   Walks the set bits of a CAM match vector from the lowest index upward and
//   emits one entry index per handshake beat. The index drives the select
//   input of the CAM read-out multiplexer. An all-zero vector that is accepted
//   produces a one-cycle miss pulse instead of any beats.
//
// Optional build macro: CAM_ITER_FLUSH_EN (adds flush_i, which drops the
//   vector being walked and any vector offered in the same cycle).
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   flush_i        (CAM_ITER_FLUSH_EN only) abandon the current vector
//   match_valid_i  match vector valid
//   match_ready_o  block can accept a match vector (IDLE)
//   match_vec_i    match vector, bit k set = entry k matched
//   sel_valid_o    sel_o holds a valid entry index (SCAN)
//   sel_ready_i    downstream consumes the current index
//   sel_o          index of the lowest pending set bit
//   sel_last_o     current index is the final pending match
//   miss_o         one-cycle pulse after an all-zero vector is accepted
//   busy_o         high while in SCAN
module cam_match_iter #(
  parameter int SELECT_WIDTH = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
`ifdef CAM_ITER_FLUSH_EN
  input  logic                         flush_i,
`endif
  input  logic                         match_valid_i,
  output logic                         match_ready_o,
  input  logic [(2**SELECT_WIDTH)-1:0] match_vec_i,
  output logic                         sel_valid_o,
  input  logic                         sel_ready_i,
  output logic [SELECT_WIDTH-1:0]      sel_o,
  output logic                         sel_last_o,
  output logic                         miss_o,
  output logic                         busy_o
);

  localparam int ENTRIES = 2**SELECT_WIDTH;
  localparam logic [ENTRIES-1:0] ONE_VEC = ENTRIES'(1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state_reg, state_next;
  logic [ENTRIES-1:0] pending_reg, pending_next;
  logic               miss_reg, miss_next;

  logic               flush;
  logic [ENTRIES-1:0] lowest_onehot;
  logic               single_bit;
  logic [SELECT_WIDTH-1:0] sel_enc;

`ifdef CAM_ITER_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Two's-complement trick isolates the lowest set bit of pending.
  assign lowest_onehot = pending_reg & (~pending_reg + ONE_VEC);
  // Exactly one bit set: clearing the lowest bit leaves nothing.
  assign single_bit = (pending_reg != '0) &&
                      ((pending_reg & (pending_reg - ONE_VEC)) == '0);

  // One-hot to binary; lowest_onehot has at most one bit set.
  always_comb begin
    sel_enc = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      if (lowest_onehot[k]) begin
        sel_enc = k[SELECT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      miss_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      miss_reg    <= miss_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    miss_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (match_valid_i && !flush) begin
          if (match_vec_i != '0) begin
            pending_next = match_vec_i;
            state_next   = SCAN;
          end else begin
            miss_next = 1'b1;
          end
        end
      end
      SCAN: begin
        if (sel_ready_i) begin
          pending_next = pending_reg & ~lowest_onehot;
          if (single_bit) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
    // Flush overrides any beat or accept in the same cycle.
    if (flush) begin
      state_next   = IDLE;
      pending_next = '0;
    end
  end

  assign match_ready_o = (state_reg == IDLE);
  assign sel_valid_o   = (state_reg == SCAN);
  assign busy_o        = (state_reg == SCAN);
  assign sel_o         = sel_enc;
  assign sel_last_o    = (state_reg == SCAN) && single_bit;
  assign miss_o        = miss_reg;

endmodule

// File: tb/tb_cam_match_iter.sv
// Directed testbench for cam_match_iter (32 entries). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_cam_match_iter;

  logic        clk_i;
  logic        rst_ni;
`ifdef CAM_ITER_FLUSH_EN
  logic        flush_i;
`endif
  logic        match_valid_i;
  logic        match_ready_o;
  logic [31:0] match_vec_i;
  logic        sel_valid_o;
  logic        sel_ready_i;
  logic [4:0]  sel_o;
  logic        sel_last_o;
  logic        miss_o;
  logic        busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  cam_match_iter #(.SELECT_WIDTH(5)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
`ifdef CAM_ITER_FLUSH_EN
    .flush_i       (flush_i),
`endif
    .match_valid_i (match_valid_i),
    .match_ready_o (match_ready_o),
    .match_vec_i   (match_vec_i),
    .sel_valid_o   (sel_valid_o),
    .sel_ready_i   (sel_ready_i),
    .sel_o         (sel_o),
    .sel_last_o    (sel_last_o),
    .miss_o        (miss_o),
    .busy_o        (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, sel_valid_o},   32'd0);
    check({tag, "_ready"}, {31'd0, match_ready_o}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy_o},        32'd0);
  endtask

  // Present vec for one accept, then walk it. Expected indices come from a
  // bit-by-bit scan of vec. rand_ready toggles sel_ready_i randomly.
  task automatic drain(input logic [31:0] vec, input bit rand_ready);
    int exp_idx[$];
    int idx;
    int cyc;
    bit rdy;
    for (int b = 0; b < 32; b++) if (vec[b]) exp_idx.push_back(b);
    match_valid_i = 1'b1;
    match_vec_i   = vec;
    sel_ready_i   = 1'b0;
    @(negedge clk_i);
    match_valid_i = 1'b0;
    match_vec_i   = 32'hDEAD_BEEF;
    idx = 0;
    cyc = 0;
    while (idx < exp_idx.size() && cyc < 300) begin
      check("scan_valid", {31'd0, sel_valid_o}, 32'd1);
      check("scan_ready", {31'd0, match_ready_o}, 32'd0);
      check("scan_sel", {27'd0, sel_o}, exp_idx[idx]);
      check("scan_last", {31'd0, sel_last_o}, (idx == exp_idx.size() - 1) ? 32'd1 : 32'd0);
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      sel_ready_i = rdy;
      if (rdy) idx++;
      cyc++;
      @(negedge clk_i);
    end
    sel_ready_i = 1'b0;
    check("beats", idx, exp_idx.size());
    check_idle("after_drain");
    $display("[TB] vec %08h: %0d beats in %0d cycles", vec, idx, cyc);
  endtask

  initial begin
    rst_ni        = 1'b1;
`ifdef CAM_ITER_FLUSH_EN
    flush_i       = 1'b0;
`endif
    match_valid_i = 1'b0;
    match_vec_i   = '0;
    sel_ready_i   = 1'b0;
    #3 rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_idle("reset");
    check("reset_sel",  {27'd0, sel_o},    32'd0);
    check("reset_last", {31'd0, sel_last_o}, 32'd0);
    check("reset_miss", {31'd0, miss_o},   32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // All-zero vector: single miss pulse, no beats.
    match_valid_i = 1'b1;
    match_vec_i   = 32'h0000_0000;
    @(negedge clk_i);
    match_valid_i = 1'b0;
    check("miss_pulse", {31'd0, miss_o}, 32'd1);
    check_idle("miss");
    @(negedge clk_i);
    check("miss_clear", {31'd0, miss_o}, 32'd0);
    check_idle("miss_after");
    $display("[TB] vec 00000000: miss");

    // Sparse vector at full rate: 0, 4, 31.
    drain(32'h8000_0011, 1'b0);
    // Full vector with random stalls.
    drain(32'hFFFF_FFFF, 1'b1);
    drain(32'h0000_0001, 1'b0);

    // Second vector held off during SCAN of 0x101.
    match_valid_i = 1'b1;
    match_vec_i   = 32'h0000_0101;
    sel_ready_i   = 1'b1;
    @(negedge clk_i);
    match_vec_i = 32'h0000_0002;
    check("hold_sel0", {27'd0, sel_o}, 32'd0);
    check("hold_ready0", {31'd0, match_ready_o}, 32'd0);
    @(negedge clk_i);
    check("hold_sel8", {27'd0, sel_o}, 32'd8);
    check("hold_last8", {31'd0, sel_last_o}, 32'd1);
    check("hold_ready8", {31'd0, match_ready_o}, 32'd0);
    @(negedge clk_i);
    check_idle("hold_gap");
    @(negedge clk_i);
    match_valid_i = 1'b0;
    check("hold_sel1", {27'd0, sel_o}, 32'd1);
    check("hold_last1", {31'd0, sel_last_o}, 32'd1);
    check("hold_valid1", {31'd0, sel_valid_o}, 32'd1);
    @(negedge clk_i);
    check_idle("hold_done");
    $display("[TB] vec 00000101 then 00000002: held off");

    // Asynchronous reset mid-scan of 0xF0 after index 4.
    match_valid_i = 1'b1;
    match_vec_i   = 32'h0000_00F0;
    sel_ready_i   = 1'b0;
    @(negedge clk_i);
    match_valid_i = 1'b0;
    check("rst_sel4", {27'd0, sel_o}, 32'd4);
    sel_ready_i = 1'b1;
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check_idle("rst_async");
    check("rst_async_sel", {27'd0, sel_o}, 32'd0);
    check("rst_async_last", {31'd0, sel_last_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("rst_no_beats", {31'd0, sel_valid_o}, 32'd0);
    end
    sel_ready_i = 1'b0;
    $display("[TB] vec 000000f0: reset mid-scan");

`ifdef CAM_ITER_FLUSH_EN
    // Flush wins over a simultaneous beat.
    match_valid_i = 1'b1;
    match_vec_i   = 32'h0000_000C;
    @(negedge clk_i);
    match_valid_i = 1'b0;
    check("flush_sel2", {27'd0, sel_o}, 32'd2);
    sel_ready_i = 1'b1;
    flush_i     = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check_idle("flush_beat");
    @(negedge clk_i);
    check("flush_no_beats", {31'd0, sel_valid_o}, 32'd0);
    sel_ready_i = 1'b0;
    // Flush wins over a simultaneous accept; no miss either.
    match_valid_i = 1'b1;
    match_vec_i   = 32'h0000_0000;
    flush_i       = 1'b1;
    @(negedge clk_i);
    match_valid_i = 1'b0;
    flush_i       = 1'b0;
    check("flush_no_miss", {31'd0, miss_o}, 32'd0);
    check_idle("flush_accept");
    $display("[TB] vec 0000000c: flushed");
    drain(32'h0000_0003, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
